// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the register index type
// used by the decoder, the register bank and the operand-select mux.
package cpu_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 16;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/scoreboard_unit.sv
// Per-register busy scoreboard: tracks in-flight writes, counts them, and
// gates instruction issue on RAW/WAW hazards.
module scoreboard_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  reg_idx_t            wr_addr,
    input  logic                iss_valid,
    input  reg_idx_t            iss_src0,
    input  reg_idx_t            iss_src1,
    input  logic                iss_dst_en,
    input  reg_idx_t            iss_dst,
    output logic                iss_ready,
    output logic [NUM_REGS-1:0] busy,
    output logic [3:0]          pending_cnt
);

    // Issue handshake: the decoder holds iss_* stable while iss_valid=1 and
    // iss_ready=0; an issue completes only on a clock edge with
    // iss_valid & iss_ready. iss_ready looks at registered busy only and never
    // at iss_valid, so a same-cycle write-back cannot release a stall early.
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                inc;
    logic                dec;

    assign iss_ready = ~busy[iss_src0] & ~busy[iss_src1] & ~(iss_dst_en & busy[iss_dst]);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && iss_ready && iss_dst_en) set_vec = idx_onehot(iss_dst);
        if (wr_en)                                clr_vec = idx_onehot(wr_addr);
    end

    // Count deltas follow real bit transitions so the counter tracks popcount(busy);
    // a set and a clear on the same index resolve to "set".
    assign inc = |(set_vec & ~busy);
    assign dec = |(clr_vec & busy & ~set_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= (busy & ~clr_vec) | set_vec;
            pending_cnt <= pending_cnt + 4'(inc) - 4'(dec);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Eight-entry 16-bit register bank with write-back port and busy scoreboard;
// r0..r7 feed the downstream 8-to-2 operand-select mux as registered values.
module regfile_scoreboard
    import cpu_pkg::NUM_REGS, cpu_pkg::reg_idx_t;
#(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  reg_idx_t          wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_valid,
    input  reg_idx_t          iss_src0,
    input  reg_idx_t          iss_src1,
    input  logic              iss_dst_en,
    input  reg_idx_t          iss_dst,
    output logic              iss_ready,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [7:0]        busy,
    output logic [3:0]        pending_cnt
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // No write-to-read bypass: the mux only ever sees the registered array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

    scoreboard_unit u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .iss_valid   (iss_valid),
        .iss_src0    (iss_src0),
        .iss_src1    (iss_src1),
        .iss_dst_en  (iss_dst_en),
        .iss_dst     (iss_dst),
        .iss_ready   (iss_ready),
        .busy        (busy),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed hazard scenarios plus randomized
// traffic checked against an array/count reference model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        iss_valid;
    logic [2:0]  iss_src0;
    logic [2:0]  iss_src1;
    logic        iss_dst_en;
    logic [2:0]  iss_dst;
    wire         iss_ready;
    wire  [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    wire  [7:0]  busy;
    wire  [3:0]  pending_cnt;

    logic [15:0] rv [8];
    assign rv[0] = r0; assign rv[1] = r1; assign rv[2] = r2; assign rv[3] = r3;
    assign rv[4] = r4; assign rv[5] = r5; assign rv[6] = r6; assign rv[7] = r7;

    regfile_scoreboard #(.DATA_W(16), .RESET_VAL(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_src0(iss_src0), .iss_src1(iss_src1),
        .iss_dst_en(iss_dst_en), .iss_dst(iss_dst), .iss_ready(iss_ready),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .busy(busy), .pending_cnt(pending_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    logic [15:0] mregs [8];
    bit          mbusy [8];
    logic [18:0] exp_q [$];
    int          checks;
    int          fails;

    function automatic logic model_ready();
        return !mbusy[iss_src0] && !mbusy[iss_src1] && !(iss_dst_en && mbusy[iss_dst]);
    endfunction

    function automatic logic [7:0] model_busy();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mbusy[i];
        return v;
    endfunction

    function automatic logic [3:0] model_cnt();
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (mbusy[i]) n++;
        return 4'(n);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mregs[i] = 16'h0000;
            mbusy[i] = 1'b0;
        end
    endtask

    // driver tasks
    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        iss_valid = 0; iss_src0 = 0; iss_src1 = 0; iss_dst_en = 0; iss_dst = 0;
    endtask

    task automatic drive_issue(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] d);
        iss_valid = 1; iss_src0 = s0; iss_src1 = s1; iss_dst_en = 1; iss_dst = d;
    endtask

    task automatic drive_write(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
    endtask

    // Advance the model with the inputs presented now, then one clock edge.
    task automatic tick();
        logic rdy;
        rdy = model_ready();
        if (wr_en) begin
            mregs[wr_addr] = wr_data;
            mbusy[wr_addr] = 1'b0;
        end
        if (iss_valid && rdy && iss_dst_en) mbusy[iss_dst] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_write(3'd1, 16'hAAAA); tick(); idle();
        drive_issue(3'd0, 3'd0, 3'd4); tick(); idle();
        #2 rst_n = 0;
        #1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rv[i] !== 16'h0000) $display("FAIL reset_r%0d: got %h expected 0000", i, rv[i]);
            if (rv[i] !== 16'h0000) fails++;
        end
        checks++;
        if (busy !== 8'h00) begin fails++; $display("FAIL reset_busy: got %h expected 00", busy); end
        checks++;
        if (pending_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", pending_cnt); end
        iss_src0 = 3'd4; iss_dst_en = 1; iss_dst = 3'd4;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", iss_ready); end
        idle();
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        drive_write(3'd5, 16'hBEEF); tick(); idle();
        checks++;
        if (r5 !== 16'hBEEF) begin fails++; $display("FAIL write_r5: got %h expected beef", r5); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rv[i] !== mregs[i]) begin fails++; $display("FAIL write_r%0d: got %h expected %h", i, rv[i], mregs[i]); end
        end
        checks++;
        if (busy !== 8'h00) begin fails++; $display("FAIL write_busy: got %h expected 00", busy); end
    endtask

    task automatic test_raw_stall();
        drive_issue(3'd0, 3'd1, 3'd3); tick(); idle();
        checks++;
        if (busy !== 8'h08) begin fails++; $display("FAIL raw_busy_set: got %h expected 08", busy); end
        checks++;
        if (pending_cnt !== 4'd1) begin fails++; $display("FAIL raw_cnt: got %0d expected 1", pending_cnt); end
        drive_issue(3'd3, 3'd0, 3'd4);
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin fails++; $display("FAIL raw_stall: got %b expected 0", iss_ready); end
        drive_write(3'd3, 16'h1234);
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin fails++; $display("FAIL raw_same_cycle_wb: got %b expected 0", iss_ready); end
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin fails++; $display("FAIL raw_release: got %b expected 1", iss_ready); end
        checks++;
        if (r3 !== 16'h1234) begin fails++; $display("FAIL raw_r3: got %h expected 1234", r3); end
        tick(); idle();
        checks++;
        if (busy !== 8'h10) begin fails++; $display("FAIL raw_issue_after: got %h expected 10", busy); end
    endtask

    task automatic test_waw_stall();
        drive_issue(3'd0, 3'd0, 3'd2); tick(); idle();
        drive_issue(3'd0, 3'd1, 3'd2);
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin fails++; $display("FAIL waw_stall: got %b expected 0", iss_ready); end
        tick();
        checks++;
        if (busy !== 8'h14) begin fails++; $display("FAIL waw_held: got %h expected 14", busy); end
        drive_write(3'd2, 16'h5A5A); tick(); wr_en = 0;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin fails++; $display("FAIL waw_release: got %b expected 1", iss_ready); end
        checks++;
        if (busy !== 8'h10) begin fails++; $display("FAIL waw_cleared: got %h expected 10", busy); end
        tick(); idle();
        checks++;
        if (busy !== 8'h14) begin fails++; $display("FAIL waw_reissue: got %h expected 14", busy); end
        checks++;
        if (pending_cnt !== model_cnt()) begin fails++; $display("FAIL waw_cnt: got %0d expected %0d", pending_cnt, model_cnt()); end
    endtask

    task automatic test_simultaneous();
        drive_write(3'd4, 16'h0404); tick();
        drive_write(3'd2, 16'h0202); tick(); idle();
        drive_issue(3'd0, 3'd0, 3'd1); tick(); idle();
        checks++;
        if (busy !== 8'h02) begin fails++; $display("FAIL simul_pre: got %h expected 02", busy); end
        drive_write(3'd1, 16'hC0DE);
        drive_issue(3'd0, 3'd0, 3'd6);
        tick(); idle();
        checks++;
        if (busy !== 8'h40) begin fails++; $display("FAIL simul_busy: got %h expected 40", busy); end
        checks++;
        if (pending_cnt !== 4'd1) begin fails++; $display("FAIL simul_cnt: got %0d expected 1", pending_cnt); end
        checks++;
        if (r1 !== 16'hC0DE) begin fails++; $display("FAIL simul_r1: got %h expected c0de", r1); end
    endtask

    task automatic test_fill_reset();
        drive_write(3'd6, 16'h0606); tick(); idle();
        for (int i = 0; i < 8; i++) begin
            drive_issue(3'(i), 3'(i), 3'(i));
            tick();
        end
        idle();
        checks++;
        if (busy !== 8'hFF) begin fails++; $display("FAIL fill_busy: got %h expected ff", busy); end
        checks++;
        if (pending_cnt !== 4'd8) begin fails++; $display("FAIL fill_cnt: got %0d expected 8", pending_cnt); end
        for (int k = 0; k < 4; k++) begin
            iss_src0 = 3'($urandom_range(0, 7)); iss_src1 = 3'($urandom_range(0, 7));
            iss_dst_en = 1'($urandom_range(0, 1)); iss_dst = 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (iss_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_%0d: got %b expected 0", k, iss_ready); end
        end
        idle();
        #1 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (busy !== 8'h00) begin fails++; $display("FAIL fill_reset_busy: got %h expected 00", busy); end
        checks++;
        if (pending_cnt !== 4'd0) begin fails++; $display("FAIL fill_reset_cnt: got %0d expected 0", pending_cnt); end
        checks++;
        if (r5 !== 16'h0000) begin fails++; $display("FAIL fill_reset_r5: got %h expected 0000", r5); end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit          hold;
        logic [18:0] e;
        hold = 0;
        repeat (400) begin
            if (!hold) begin
                iss_valid  = 1'($urandom_range(0, 1));
                iss_src0   = 3'($urandom_range(0, 7));
                iss_src1   = 3'($urandom_range(0, 7));
                iss_dst_en = 1'($urandom_range(0, 3) != 0);
                iss_dst    = 3'($urandom_range(0, 7));
            end
            wr_en   = 1'($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 16'($urandom);
            #1;
            checks++;
            if (iss_ready !== model_ready()) begin
                fails++;
                $display("FAIL rand_ready: got %b expected %b (busy %h)", iss_ready, model_ready(), model_busy());
            end
            if (wr_en) exp_q.push_back({wr_addr, wr_data});
            hold = iss_valid && !model_ready();
            tick();
            checks++;
            if (busy !== model_busy()) begin fails++; $display("FAIL rand_busy: got %h expected %h", busy, model_busy()); end
            checks++;
            if (pending_cnt !== model_cnt()) begin fails++; $display("FAIL rand_cnt: got %0d expected %0d", pending_cnt, model_cnt()); end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rv[e[18:16]] !== e[15:0]) begin
                    fails++;
                    $display("FAIL rand_wb_r%0d: got %h expected %h", e[18:16], rv[e[18:16]], e[15:0]);
                end
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rv[i] !== mregs[i]) begin fails++; $display("FAIL rand_r%0d: got %h expected %h", i, rv[i], mregs[i]); end
            end
        end
        idle();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        idle();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        test_reset();
        test_write_read();
        test_raw_stall();
        test_waw_stall();
        test_simultaneous();
        test_fill_reset();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
